display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_if.sv | 21 ++
 rtl/display_scan_ctrl.sv | 78 +++++++
 2 files changed

// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the display scan controller and the digit/segment driver side.
// master = scan controller, slave = consumer that supplies blink/dp requests.
interface display_scan_ctrl_if;
  logic [3:0] blink_mask;
  logic       dp_en;
  logic [1:0] sel;
  logic [3:0] an;
  logic       dp;
  logic       frame_tick;
  logic       blink_phase;

  modport master (
    input  blink_mask, dp_en,
    output sel, an, dp, frame_tick, blink_phase
  );

  modport slave (
    output blink_mask, dp_en,
    input  sel, an, dp, frame_tick, blink_phase
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with per-digit blinking and a dp indicator.
// Optional anti-ghosting blanking at slot start: define DISPLAY_GHOST_BLANK_EN.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 250000,
  parameter int BLINK_FRAMES = 50,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.master bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FR_MAX  = FW'(BLINK_FRAMES - 1);

  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be at least 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_frames
    $error("BLINK_FRAMES must be at least 1");
  end
  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("BLANK_CYCLES must be below REFRESH_DIV");
  end

  logic [PW-1:0] prescaler, pre_n;
  logic [FW-1:0] framecnt, frame_n;
  logic [1:0]    sel_n;
  logic          phase_n, slot_end, wrap, an_blank, dp_n;
  logic [3:0]    an_n;

  // Everything visible is computed from next-state values so that sel, an,
  // dp and blink_phase all update together on a single edge.
  always_comb begin
    slot_end = (prescaler == PRE_MAX);
    pre_n    = slot_end ? '0 : prescaler + PW'(1);
    sel_n    = slot_end ? bus.sel + 2'd1 : bus.sel;
    wrap     = slot_end && (bus.sel == 2'd3);
    frame_n  = framecnt;
    phase_n  = bus.blink_phase;
    if (wrap) begin
      frame_n = (framecnt == FR_MAX) ? '0 : framecnt + FW'(1);
      if (framecnt == FR_MAX) phase_n = ~bus.blink_phase;
    end
    an_blank = bus.blink_mask[sel_n] && phase_n;
    an_n     = an_blank ? 4'b1111 : ~(4'b0001 << sel_n);
    dp_n     = !((sel_n == 2'd2) && bus.dp_en && !phase_n);
`ifdef DISPLAY_GHOST_BLANK_EN
    if (pre_n < PW'(BLANK_CYCLES)) begin
      an_n = 4'b1111;
      dp_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler       <= '0;
      framecnt        <= '0;
      bus.sel         <= 2'd0;
      bus.blink_phase <= 1'b0;
      bus.an          <= 4'b1111;
      bus.dp          <= 1'b1;
      bus.frame_tick  <= 1'b0;
    end else begin
      prescaler       <= pre_n;
      framecnt        <= frame_n;
      bus.sel         <= sel_n;
      bus.blink_phase <= phase_n;
      bus.an          <= an_n;
      bus.dp          <= dp_n;
      bus.frame_tick  <= wrap;
    end
  end

endmodule
